// File: rtl/bcd_seq_checker.sv
// Sequence checker for an upstream modulo counter: hunts for a count stream,
// locks after LOCK_LEN correct increments, then flags slips, range errors and wraps.
module bcd_seq_checker #(
  parameter int MODULUS  = 10,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       count_in,
  input  logic             count_valid,
  input  logic             clear_err,
  output logic             locked,
  output logic             seq_err,
  output logic             range_err,
  output logic             wrap_pulse,
  output logic [3:0]       tens,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [4:0] MOD_V  = 5'(MODULUS);
  localparam logic [3:0] MAX_V  = 4'(MODULUS - 1);
  localparam logic [3:0] LOCK_V = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             seq_err_q, seq_err_d;
  logic             range_err_q, range_err_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic       in_range;
  logic       match;
  logic       err_inc;
  logic [3:0] expected;
  logic [3:0] good_cnt_inc;

  // Explicit modulo successor; 4-bit natural wrap would be wrong for MODULUS < 16.
  assign expected     = (prev_q == MAX_V) ? 4'd0 : prev_q + 4'd1;
  assign in_range     = {1'b0, count_in} < MOD_V;
  assign match        = (count_in == expected);
  assign good_cnt_inc = good_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_cnt_d   = good_cnt_q;
    tens_d       = tens_q;
    err_inc      = 1'b0;
    seq_err_d    = 1'b0;
    range_err_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (count_valid) begin
      case (state_q)
        HUNT: begin
          if (in_range) begin
            prev_d     = count_in;
            good_cnt_d = 4'd0;
            state_d    = SYNC;
          end else begin
            range_err_d = 1'b1;
          end
        end
        SYNC: begin
          if (!in_range) begin
            range_err_d = 1'b1;
            state_d     = HUNT;
          end else if (match) begin
            good_cnt_d = good_cnt_inc;
            prev_d     = count_in;
            if (good_cnt_inc == LOCK_V) state_d = LOCKED;
          end else begin
            good_cnt_d = 4'd0;
            prev_d     = count_in;
          end
        end
        LOCKED: begin
          if (!in_range) begin
            seq_err_d   = 1'b1;
            range_err_d = 1'b1;
            err_inc     = 1'b1;
            state_d     = HUNT;
          end else if (match) begin
            prev_d = count_in;
            if (prev_q == MAX_V) begin
              wrap_pulse_d = 1'b1;
              tens_d       = (tens_q == MAX_V) ? 4'd0 : tens_q + 4'd1;
            end
          end else begin
            seq_err_d  = 1'b1;
            err_inc    = 1'b1;
            prev_d     = count_in;
            good_cnt_d = 4'd0;
            state_d    = SYNC;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear takes precedence over a same-cycle increment.
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      prev_q       <= 4'd0;
      good_cnt_q   <= 4'd0;
      tens_q       <= 4'd0;
      err_count_q  <= '0;
      seq_err_q    <= 1'b0;
      range_err_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_cnt_q   <= good_cnt_d;
      tens_q       <= tens_d;
      err_count_q  <= err_count_d;
      seq_err_q    <= seq_err_d;
      range_err_q  <= range_err_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign seq_err    = seq_err_q;
  assign range_err  = range_err_q;
  assign wrap_pulse = wrap_pulse_q;
  assign tens       = tens_q;
  assign err_count  = err_count_q;

endmodule
